// File: rtl/uart_tx_stream.sv
// Buffered UART transmitter: valid/ready stream into a small FIFO, serialised LSB-first
// with run-time parity mode and back-to-back frames.
module uart_tx_stream #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 10417,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [DATA_BITS-1:0]             s_data,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [1:0]                       parity_mode,
    output logic                             tx,
    output logic                             busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int BIT_W = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic                 s_ready_q, s_ready_d;
    state_e               state_q, state_d;
    logic [CNT_W-1:0]     baud_q, baud_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_en_q, par_en_d;
    logic                 par_bit_q, par_bit_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;

    logic                 push;
    logic                 pop;
    logic                 bit_done;
    logic [DATA_BITS-1:0] head;

    // NOTE: every signal gets a default at the top of the block so no path leaves it
    // unassigned; otherwise synthesis would infer a latch to hold the old value.
    always_comb begin
        push      = s_valid && s_ready_q;
        pop       = 1'b0;
        head      = mem_q[rd_ptr_q];
        bit_done  = (baud_q == CNT_W'(CLKS_PER_BIT - 1));
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        tx_d      = tx_q;

        if (state_q != S_IDLE) begin
            baud_d = bit_done ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (level_q != '0) begin
                    pop = 1'b1;
                end
            end
            S_START: begin
                if (bit_done) begin
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                        bit_d = '0;
                        if (par_en_q) begin
                            state_d = S_PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_done) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                    bit_d   = '0;
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                        // Chain straight into the next start bit when a word is waiting.
                        if (level_q != '0) begin
                            pop = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        if (pop) begin
            state_d   = S_START;
            tx_d      = 1'b0;
            baud_d    = '0;
            bit_d     = '0;
            shift_d   = head;
            par_en_d  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
            par_bit_d = (^head) ^ (parity_mode == 2'b10);
        end

        wr_ptr_d  = wr_ptr_q + PTR_W'(push);
        rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
        level_d   = level_q + LVL_W'(push) - LVL_W'(pop);
        s_ready_d = (level_d != LVL_W'(FIFO_DEPTH));
        busy_d    = (state_d != S_IDLE) || (level_d != '0);
    end

    // NOTE: the storage array carries no reset; validity is tracked by the level and
    // pointers alone, which keeps the array mappable onto plain RAM or flop banks.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            s_ready_q <= 1'b1;
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            s_ready_q <= s_ready_d;
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign s_ready    = s_ready_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_uart_tx_stream.sv
// Bench for uart_tx_stream: one- and two-stop-bit instances side by side, each checked
// every cycle against a frame-timeline model, plus hand-computed frame literals.
module tb_uart_tx_stream;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk         = 1'b0;
    logic       rst_n       = 1'b0;
    logic [7:0] s_data      = '0;
    logic       s_valid     = 1'b0;
    logic [1:0] parity_mode = 2'b00;
    logic [1:0] s_ready_w;
    logic [1:0] tx_w;
    logic [1:0] busy_w;
    logic [2:0] level_w [2];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Frame as a bit list: start, data LSB first, optional parity, stop bits (all ones).
    function automatic int build_frame(input logic [7:0] d, input logic [1:0] mode,
                                       input int stops, output logic [15:0] f);
        int n;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i + 1] = d[i];
        n = 9;
        if (mode == 2'b01) begin
            f[n] = ^d;
            n++;
        end else if (mode == 2'b10) begin
            f[n] = ~^d;
            n++;
        end
        return n + stops;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        uart_tx_stream #(
            .DATA_BITS   (8),
            .CLKS_PER_BIT(CPB),
            .STOP_BITS   (g + 1),
            .FIFO_DEPTH  (DEPTH)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .s_data     (s_data),
            .s_valid    (s_valid),
            .s_ready    (s_ready_w[g]),
            .parity_mode(parity_mode),
            .tx         (tx_w[g]),
            .busy       (busy_w[g]),
            .fifo_level (level_w[g])
        );

        logic [7:0]  mq[$];
        bit          on_line = 1'b0;
        bit          acc     = 1'b0;
        int          cyc     = 0;
        int          flen    = 0;
        logic [15:0] fbits   = '1;

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mq.delete();
                on_line = 1'b0;
                cyc     = 0;
            end else begin
                acc = s_valid && (mq.size() < DEPTH);
                if (on_line) begin
                    cyc++;
                    if (cyc == flen) on_line = 1'b0;
                end
                if (!on_line && mq.size() != 0) begin
                    flen    = build_frame(mq.pop_front(), parity_mode, g + 1, fbits) * CPB;
                    on_line = 1'b1;
                    cyc     = 0;
                end
                if (acc) mq.push_back(s_data);
            end
        end

        always @(negedge clk) begin
            check($sformatf("tx[%0d]", g), int'(tx_w[g]),
                  on_line ? int'(fbits[cyc / CPB]) : 1);
            check($sformatf("busy[%0d]", g), int'(busy_w[g]),
                  int'(on_line || mq.size() != 0));
            check($sformatf("level[%0d]", g), int'(level_w[g]), mq.size());
            check($sformatf("ready[%0d]", g), int'(s_ready_w[g]), int'(mq.size() < DEPTH));
        end
    end

    task automatic wait_ready();
        int t = 0;
        while (!s_ready_w[0] && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("ready_wait", int'(s_ready_w[0]), 1);
    endtask

    task automatic push_word(input logic [7:0] d, input logic [1:0] mode);
        @(posedge clk);
        #1;
        s_data      = d;
        parity_mode = mode;
        s_valid     = 1'b1;
        wait_ready();
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    // Called right after the accepting edge; k counts negedges from there.
    task automatic frame_check(input int g, input logic [15:0] f, input int nbits,
                               input int toggle_k);
        for (int k = 0; k <= nbits * CPB + 1; k++) begin
            @(negedge clk);
            if (k == toggle_k) parity_mode = 2'b10;
            if (k == 0) check("tx_before_start", int'(tx_w[g]), 1);
            if (k == 1) check("tx_low_after_accept", int'(tx_w[g]), 0);
            if (k >= 1 && k <= nbits * CPB && (k - 1) % CPB == 2)
                check($sformatf("frame_bit%0d", (k - 1) / CPB), int'(tx_w[g]),
                      int'(f[(k - 1) / CPB]));
            if (k == nbits * CPB) check("busy_last_cycle", int'(busy_w[g]), 1);
            if (k == nbits * CPB + 1) check("busy_dropped", int'(busy_w[g]), 0);
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy_w != 2'b00 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("idle", int'(busy_w), 0);
    endtask

    task automatic reset_checks(input string tag);
        for (int g = 0; g < 2; g++) begin
            check($sformatf("%s_tx%0d", tag, g), int'(tx_w[g]), 1);
            check($sformatf("%s_busy%0d", tag, g), int'(busy_w[g]), 0);
            check($sformatf("%s_ready%0d", tag, g), int'(s_ready_w[g]), 1);
            check($sformatf("%s_level%0d", tag, g), int'(level_w[g]), 0);
        end
    endtask

    initial begin
        logic [7:0] burst [6];
        burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33;
        burst[3] = 8'h44; burst[4] = 8'h55; burst[5] = 8'h66;

        @(posedge clk);
        #1;
        reset_checks("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 0xA5 even parity: 44-cycle frame, parity 0.
        push_word(8'hA5, 2'b01);
        frame_check(0, 16'(11'b1_0_10100101_0), 11, -1);
        wait_idle();

        // Odd parity on 0x01 and 0x03, then a parity-less frame.
        push_word(8'h01, 2'b10);
        frame_check(0, 16'(11'b1_0_00000001_0), 11, -1);
        wait_idle();
        push_word(8'h03, 2'b10);
        frame_check(0, 16'(11'b1_1_00000011_0), 11, -1);
        wait_idle();
        push_word(8'h3C, 2'b00);
        frame_check(0, 16'(10'b1_00111100_0), 10, -1);
        wait_idle();

        // Two stop bits on the second instance.
        push_word(8'h3C, 2'b11);
        frame_check(1, 16'(11'b1_1_00111100_0), 11, -1);
        wait_idle();

        // Mode flips to odd mid-data; the frame keeps its latched even parity.
        push_word(8'hA5, 2'b01);
        frame_check(0, 16'(11'b1_0_10100101_0), 11, 10);
        parity_mode = 2'b01;
        wait_idle();

        // Streamed burst with s_valid held: FIFO fills, frames chain with no gap.
        @(posedge clk);
        #1;
        parity_mode = 2'b01;
        s_valid     = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s_data = burst[i];
            wait_ready();
            @(posedge clk);
            #1;
            if (i == 4) begin
                check("burst_level_full", int'(level_w[0]), 4);
                check("burst_ready_low", int'(s_ready_w[0]), 0);
            end
        end
        s_valid = 1'b0;
        wait_idle();

        // Asynchronous reset during data bit 3, then a clean frame.
        push_word(8'hA5, 2'b01);
        repeat (18) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        reset_checks("async_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_word(8'h5A, 2'b01);
        frame_check(0, 16'(11'b1_0_01011010_0), 11, -1);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
